// File: rtl/core_seq_pkg.sv
// rtl/core_seq_pkg.sv - shared sequencer state and interrupt-acknowledge encodings
package core_seq_pkg;

  typedef enum logic [2:0] {
    FETCH_S   = 3'd0,
    DECODE_S  = 3'd1,
    EXECUTE_S = 3'd2,
    COMMIT_S  = 3'd3,
    INTENT_S  = 3'd4,
    HALTED_S  = 3'd5
  } seq_state_e;

  localparam logic [1:0] ACK_NONE = 2'b00;
  localparam logic [1:0] ACK_INT0 = 2'b01;
  localparam logic [1:0] ACK_INT1 = 2'b10;

endpackage

// File: rtl/int_sync.sv
// rtl/int_sync.sv - two-flop synchronizer with rising-edge detect for one interrupt line
module int_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - instruction phase sequencer with interrupt entry and debug halt/step
module core_sequencer
  import core_seq_pkg::*;
(
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       EXEC_WAIT,
  input  logic       STOP_INSTR,
  input  logic       IE,
  input  logic       INT0,
  input  logic       INT1,
  input  logic       HALT_REQ,
  input  logic       RUN_REQ,
  input  logic       STEP_REQ,
  output logic       FETCH,
  output logic       DECODE,
  output logic       EXECUTE,
  output logic       COMMIT,
  output logic       INT_ENTRY,
  output logic [1:0] INT_ACK,
  output logic       STOPPED
);

  seq_state_e state;
  seq_state_e state_next;

  logic rise_0;
  logic rise_1;
  logic pending_0;
  logic pending_1;
  logic halt_pending;
  logic step_active;
  logic stop_latched;
  logic ack_0;
  logic ack_1;
  logic leave_halt;

  int_sync u_sync_0 (.clk(CLK), .rst_n(RESETN), .async_in(INT0), .rise(rise_0));
  int_sync u_sync_1 (.clk(CLK), .rst_n(RESETN), .async_in(INT1), .rise(rise_1));

  assign ack_0      = (state == INTENT_S) && pending_0;
  assign ack_1      = (state == INTENT_S) && !pending_0 && pending_1;
  assign leave_halt = (state == HALTED_S) && (RUN_REQ || STEP_REQ);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= FETCH_S;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    FETCH      = 1'b0;
    DECODE     = 1'b0;
    EXECUTE    = 1'b0;
    COMMIT     = 1'b0;
    INT_ENTRY  = 1'b0;
    INT_ACK    = ACK_NONE;
    STOPPED    = 1'b0;
    case (state)
      FETCH_S: begin
        FETCH      = 1'b1;
        state_next = DECODE_S;
      end
      DECODE_S: begin
        DECODE     = 1'b1;
        state_next = EXECUTE_S;
      end
      EXECUTE_S: begin
        EXECUTE    = 1'b1;
        state_next = EXEC_WAIT ? EXECUTE_S : COMMIT_S;
      end
      COMMIT_S: begin
        COMMIT = 1'b1;
        // Debug stops outrank interrupts, so a step never enters a handler.
        if (stop_latched || halt_pending || step_active) begin
          state_next = HALTED_S;
        end else if (IE && (pending_0 || pending_1)) begin
          state_next = INTENT_S;
        end else begin
          state_next = FETCH_S;
        end
      end
      INTENT_S: begin
        INT_ENTRY  = 1'b1;
        INT_ACK    = pending_0 ? ACK_INT0 : ACK_INT1;
        state_next = FETCH_S;
      end
      HALTED_S: begin
        STOPPED = 1'b1;
        if (RUN_REQ || STEP_REQ) begin
          state_next = FETCH_S;
        end
      end
      default: begin
        state_next = FETCH_S;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pending_0    <= 1'b0;
      pending_1    <= 1'b0;
      halt_pending <= 1'b0;
      step_active  <= 1'b0;
      stop_latched <= 1'b0;
    end else begin
      // A fresh edge wins over the acknowledge in the same cycle.
      pending_0 <= (pending_0 && !ack_0) || rise_0;
      pending_1 <= (pending_1 && !ack_1) || rise_1;

      if (state == HALTED_S) begin
        if (RUN_REQ) begin
          halt_pending <= 1'b0;
        end
      end else if (HALT_REQ) begin
        halt_pending <= 1'b1;
      end

      if (state == HALTED_S) begin
        step_active <= STEP_REQ && !RUN_REQ;
      end else if (state == COMMIT_S && state_next == HALTED_S) begin
        step_active <= 1'b0;
      end

      if (leave_halt) begin
        stop_latched <= 1'b0;
      end else if (state == EXECUTE_S && STOP_INSTR) begin
        stop_latched <= 1'b1;
      end
    end
  end

endmodule
